// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared debug-port widths, register indices and bridge state encoding
package dbg_pkg;

  localparam int DBG_ADDR_W = 2;
  localparam int DBG_DATA_W = 32;

  // The bridge passes these through untouched; the SoC assigns their meaning.
  localparam logic [DBG_ADDR_W-1:0] DBG_REG_CMD    = 2'd0;
  localparam logic [DBG_ADDR_W-1:0] DBG_REG_ADDR   = 2'd1;
  localparam logic [DBG_ADDR_W-1:0] DBG_REG_DATA   = 2'd2;
  localparam logic [DBG_ADDR_W-1:0] DBG_REG_STATUS = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    RESP = ST_RESP
  } state_e;

endpackage

// File: rtl/dbg_host_bridge_if.sv
// rtl/dbg_host_bridge_if.sv - host command/response port and SoC debug port bundle
interface dbg_host_bridge_if import dbg_pkg::*;;

  logic                  host_valid;
  logic                  host_ready;
  logic [DBG_ADDR_W-1:0] host_addr;
  logic                  host_wr;
  logic [DBG_DATA_W-1:0] host_wdata;
  logic                  rsp_valid;
  logic [DBG_DATA_W-1:0] rsp_rdata;
  logic                  rsp_timeout;

  logic [DBG_ADDR_W-1:0] addr;
  logic [DBG_DATA_W-1:0] write_data;
  logic [DBG_DATA_W-1:0] read_data;
  logic                  wr_en;
  logic                  req;
  logic                  ack;

  // master is the bridge; slave is the host plus SoC environment around it
  modport master (
    input  host_valid, host_addr, host_wr, host_wdata, read_data, ack,
    output host_ready, rsp_valid, rsp_rdata, rsp_timeout,
           addr, write_data, wr_en, req
  );

  modport slave (
    output host_valid, host_addr, host_wr, host_wdata, read_data, ack,
    input  host_ready, rsp_valid, rsp_rdata, rsp_timeout,
           addr, write_data, wr_en, req
  );

endinterface

// File: rtl/dbg_host_bridge.sv
// rtl/dbg_host_bridge.sv - serialises host register accesses onto the SoC debug req/ack port
module dbg_host_bridge
  import dbg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input logic              clk,
  input logic              rst,
  dbg_host_bridge_if.master bus
);

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.host_ready  <= 1'b1;
      bus.req         <= 1'b0;
      bus.wr_en       <= 1'b0;
      bus.addr        <= '0;
      bus.write_data  <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.host_valid) begin
            bus.addr       <= bus.host_addr;
            bus.write_data <= bus.host_wdata;
            bus.wr_en      <= bus.host_wr;
            bus.req        <= 1'b1;
            bus.host_ready <= 1'b0;
            cnt            <= '0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          // ack is checked first so a coincident ack beats the timeout
          if (bus.ack) begin
            bus.rsp_rdata   <= bus.wr_en ? '0 : bus.read_data;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.req         <= 1'b0;
            state           <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) begin
            bus.rsp_rdata   <= '0;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            bus.req         <= 1'b0;
            state           <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          bus.rsp_valid  <= 1'b0;
          bus.host_ready <= 1'b1;
          bus.wr_en      <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_host_bridge.sv
// tb/tb_dbg_host_bridge.sv - self-checking bench for dbg_host_bridge with a transaction-level model
module tb_dbg_host_bridge;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dbg_host_bridge_if bus ();

  dbg_host_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access seen from the host: ack_at is the req-high cycle (1-based) carrying ack;
  // outside 1..TO no ack is driven and a timeout response is expected.
  task automatic do_txn(input logic [1:0] a, input logic w, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_at, input bit late_ack,
                        input bit chain, input logic [1:0] ca, input logic cw,
                        input logic [31:0] cwd);
    int          guard = 0;
    bit          hit;
    int          n;
    logic        exp_to;
    logic [31:0] exp_rd;
    hit    = (ack_at >= 1 && ack_at <= TO);
    n      = hit ? ack_at : TO;
    exp_to = !hit;
    exp_rd = (hit && !w) ? rd : 32'h0;
    while (bus.host_ready !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_cmd", bus.host_ready, 1);
    bus.host_valid = 1'b1;
    bus.host_addr  = a;
    bus.host_wr    = w;
    bus.host_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    if (chain) begin
      bus.host_addr  = ca;
      bus.host_wr    = cw;
      bus.host_wdata = cwd;
    end else begin
      bus.host_valid = 1'b0;
      bus.host_wdata = $urandom();
    end
    for (int i = 1; i <= n; i++) begin
      chk("req_high", bus.req, 1);
      chk("addr_stable", bus.addr, a);
      chk("wdata_stable", bus.write_data, wd);
      chk("wr_en_stable", bus.wr_en, w);
      chk("busy_not_ready", bus.host_ready, 0);
      chk("no_rsp_in_wait", bus.rsp_valid, 0);
      bus.ack       = (i == ack_at);
      bus.read_data = (i == ack_at) ? rd : $urandom();
      @(negedge clk);
    end
    bus.ack       = 1'b0;
    bus.read_data = $urandom();
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_timeout", bus.rsp_timeout, exp_to);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("req_dropped", bus.req, 0);
    chk("resp_not_ready", bus.host_ready, 0);
    if (late_ack) bus.ack = 1'b1;
    @(negedge clk);
    chk("rsp_one_cycle", bus.rsp_valid, 0);
    chk("ready_back", bus.host_ready, 1);
    chk("req_gap", bus.req, 0);
    chk("wr_en_cleared", bus.wr_en, 0);
    if (late_ack) begin
      @(negedge clk);
      bus.ack = 1'b0;
      chk("late_ack_no_rsp", bus.rsp_valid, 0);
      chk("late_ack_no_req", bus.req, 0);
      @(negedge clk);
      chk("late_ack_no_rsp2", bus.rsp_valid, 0);
    end
  endtask

  initial begin
    int guard;
    rst            = 1'b1;
    bus.host_valid = 1'b0;
    bus.host_addr  = '0;
    bus.host_wr    = 1'b0;
    bus.host_wdata = '0;
    bus.read_data  = '0;
    bus.ack        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_host_ready", bus.host_ready, 1);
    chk("rst_req", bus.req, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req", bus.req, 0);

    // directed: write, read, timeout with late ack, ack on the timeout cycle
    do_txn(2'd1, 1'b1, 32'h12345678, 32'hA5A5A5A5, 5, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    do_txn(2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    do_txn(2'd3, 1'b0, 32'h0, 32'h0BADF00D, 0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0);
    do_txn(2'd0, 1'b0, 32'h0, 32'hCAFEF00D, TO, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);

    // back-to-back: host_valid stays high across both commands
    do_txn(2'd1, 1'b1, 32'h11111111, 32'h0, 2, 1'b0, 1'b1, 2'd2, 1'b0, 32'h22222222);
    do_txn(2'd2, 1'b0, 32'h22222222, 32'h33333333, 3, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);

    // reset while the request is outstanding
    guard = 0;
    while (bus.host_ready !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    bus.host_valid = 1'b1;
    bus.host_addr  = 2'd3;
    bus.host_wr    = 1'b1;
    bus.host_wdata = 32'h5555AAAA;
    @(posedge clk);
    @(negedge clk);
    bus.host_valid = 1'b0;
    repeat (3) begin
      chk("pre_rst_req", bus.req, 1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req", bus.req, 0);
    chk("midrst_ready", bus.host_ready, 1);
    chk("midrst_rsp", bus.rsp_valid, 0);
    chk("midrst_addr", bus.addr, 0);
    chk("midrst_wdata", bus.write_data, 0);
    chk("midrst_wr_en", bus.wr_en, 0);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    repeat (4) begin
      chk("stray_ack_no_rsp", bus.rsp_valid, 0);
      chk("stray_ack_no_req", bus.req, 0);
      @(negedge clk);
    end

    // randomized accesses; ack_at beyond TO means the SoC never answers
    for (int k = 0; k < 16; k++) begin
      do_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
             int'($urandom_range(0, TO + 2)), 1'($urandom_range(0, 1)), 1'b0,
             2'd0, 1'b0, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
